// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready byte handshake into the buffered UART transmitter.
// The producer drives tx_valid/tx_data; the transmitter returns tx_ready.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of a configurable-format serialiser.
// Define UART_TX_CTS_EN to add cts_n flow control on frame starts.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | line high, baud counter held at 0, waiting for data
// ST_START  | start bit (low) for one bit period
// ST_DATA   | DATA_BITS bit periods, LSB first
// ST_PARITY | parity bit period (not entered when PARITY = 0)
// ST_STOP   | STOP_BITS high periods, then next start or idle
module uart_tx_fifo #(
  parameter int MAIN_CLK   = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  uart_tx_fifo_if.slave               tx_if,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef UART_TX_CTS_EN
  ,
  input  logic                        cts_n
`endif
);

  localparam int BAUD_DIVIDE = MAIN_CLK / BAUD;
  localparam int CNT_W       = $clog2(BAUD_DIVIDE);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BAUD_DIVIDE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   LEVEL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 head_parity;
  logic                 push;
  logic                 pop;
  logic                 cts_ok;
  logic                 frame_end;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  // Resets to "not clear" so nothing starts before the line partner is sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cts_sync <= 2'b11;
    else          cts_sync <= {cts_sync[0], cts_n};
  end

  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign head        = mem[rd_ptr];
  assign head_parity = (PARITY == 1) ? ~^head : ^head;

  assign tx_if.tx_ready = (fifo_level != LEVEL_FULL);
  assign push           = tx_if.tx_valid & tx_if.tx_ready;
  assign frame_end      = (state == ST_STOP) && (baud_cnt == '0) && (bit_cnt == STOP_LAST);
  assign pop            = (fifo_level != '0) & cts_ok & ((state == ST_IDLE) | frame_end);
  assign busy           = (state != ST_IDLE) | (fifo_level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_if.tx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
        2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      uart_tx    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          uart_tx  <= 1'b1;
        end
        ST_START: begin
          if (baud_cnt == '0) begin
            baud_cnt  <= BAUD_LAST;
            bit_cnt   <= '0;
            uart_tx   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end
        ST_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LAST;
            if (bit_cnt != DATA_LAST) begin
              bit_cnt   <= bit_cnt + 4'd1;
              uart_tx   <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end else if (PARITY != 0) begin
              uart_tx <= parity_bit;
              state   <= ST_PARITY;
            end else begin
              bit_cnt <= '0;
              uart_tx <= 1'b1;
              state   <= ST_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end
        ST_PARITY: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= '0;
            uart_tx  <= 1'b1;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end
        ST_STOP: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end else if (bit_cnt != STOP_LAST) begin
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= bit_cnt + 4'd1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          uart_tx <= 1'b1;
        end
      endcase

      // A pop only happens from IDLE or at the last stop cycle; it overrides the
      // idle transition so back-to-back frames have no gap.
      if (pop) begin
        shift_reg  <= head;
        parity_bit <= head_parity;
        baud_cnt   <= BAUD_LAST;
        uart_tx    <= 1'b0;
        state      <= ST_START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, 7E2 and 8O1 instances at BAUD_DIVIDE=10.
// Checks frame bit timing, FIFO full/back-to-back, mid-frame reset and (with UART_TX_CTS_EN) flow control.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
`ifdef UART_TX_CTS_EN
  logic cts_n = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8)) if_n ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if_e ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_o ();

  logic       tx_n, tx_e, tx_o;
  logic       busy_n, busy_e, busy_o;
  logic [2:0] lvl_n, lvl_e, lvl_o;

  uart_tx_fifo #(.MAIN_CLK(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
    .clk(clk), .reset_n(reset_n), .tx_if(if_n), .uart_tx(tx_n), .busy(busy_n),
    .fifo_level(lvl_n)
`ifdef UART_TX_CTS_EN
    , .cts_n(cts_n)
`endif
  );

  uart_tx_fifo #(.MAIN_CLK(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dut_e (
    .clk(clk), .reset_n(reset_n), .tx_if(if_e), .uart_tx(tx_e), .busy(busy_e),
    .fifo_level(lvl_e)
`ifdef UART_TX_CTS_EN
    , .cts_n(cts_n)
`endif
  );

  uart_tx_fifo #(.MAIN_CLK(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_o (
    .clk(clk), .reset_n(reset_n), .tx_if(if_o), .uart_tx(tx_o), .busy(busy_o),
    .fifo_level(lvl_o)
`ifdef UART_TX_CTS_EN
    , .cts_n(cts_n)
`endif
  );

  int   n_asserts = 0;
  int   n_fail = 0;
  int   sel = 0;
  logic line, busy_sel;
  logic [7:0] w4 [6];

  always_comb begin
    line     = tx_n;
    busy_sel = busy_n;
    case (sel)
      1: begin line = tx_e; busy_sel = busy_e; end
      2: begin line = tx_o; busy_sel = busy_o; end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bit k is f[k]; checks the first and last cycle of every bit period.
  task automatic check_frame(input logic [11:0] f, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_first"}, line, f[k]);
      chk({tag, "_busy"}, busy_sel, 1'b1);
      repeat (9) tick();
      chk({tag, "_last"}, line, f[k]);
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int cnt;
    if_n.tx_valid = 1'b0; if_n.tx_data = '0;
    if_e.tx_valid = 1'b0; if_e.tx_data = '0;
    if_o.tx_valid = 1'b0; if_o.tx_data = '0;
    w4 = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_line", tx_n, 1'b1);
    chk("rst_ready", if_n.tx_ready, 1'b1);
    chk("rst_busy", busy_n, 1'b0);
    chk("rst_level", lvl_n, 3'd0);
    chk("rst_line_e", tx_e, 1'b1);
    chk("rst_line_o", tx_o, 1'b1);
    reset_n = 1'b1;
    tick();

    // 8N1, 0x55
    sel = 0;
    if_n.tx_data = 8'h55; if_n.tx_valid = 1'b1;
    tick();
    if_n.tx_valid = 1'b0;
    chk("t1_level_after_push", lvl_n, 3'd1);
    chk("t1_line_before_start", tx_n, 1'b1);
    tick();
    check_frame({2'b00, 1'b1, 8'h55, 1'b0}, 10, "t1");
    chk("t1_busy_end", busy_n, 1'b0);
    chk("t1_line_end", tx_n, 1'b1);

    // 7E2, 0x41: parity 0, two stop bits, 110 cycles
    sel = 1;
    if_e.tx_data = 7'h41; if_e.tx_valid = 1'b1;
    tick();
    if_e.tx_valid = 1'b0;
    tick();
    check_frame({1'b0, 2'b11, 1'b0, 7'h41, 1'b0}, 11, "t2");
    chk("t2_busy_end", busy_e, 1'b0);

    // 8O1: 0x00 -> parity 1, 0x01 -> parity 0, back to back
    sel = 2;
    if_o.tx_data = 8'h00; if_o.tx_valid = 1'b1;
    tick();
    if_o.tx_data = 8'h01;
    tick();
    if_o.tx_valid = 1'b0;
    check_frame({1'b1, 1'b1, 8'h00, 1'b0}, 11, "t3a");
    check_frame({1'b1, 1'b0, 8'h01, 1'b0}, 11, "t3b");
    chk("t3_busy_end", busy_o, 1'b0);

    // Depth 4, six words held on tx_valid
    sel = 0;
    fork
      begin : prod
        int idx;
        int guard;
        logic acc;
        int exp_lvl [5];
        idx = 0;
        guard = 0;
        exp_lvl = '{1, 1, 2, 3, 4};
        if_n.tx_data = w4[0];
        if_n.tx_valid = 1'b1;
        while (idx < 6 && guard < 400) begin
          acc = if_n.tx_ready;
          tick();
          guard++;
          if (acc) idx++;
          if (guard <= 5) chk("t4_level", lvl_n, exp_lvl[guard-1]);
          if (guard == 5) chk("t4_ready_full", if_n.tx_ready, 1'b0);
          if (idx < 6) if_n.tx_data = w4[idx];
        end
        if_n.tx_valid = 1'b0;
        chk("t4_words_pushed", idx, 6);
      end
      begin : mon
        tick();
        tick();
        for (int j = 0; j < 6; j++) check_frame({2'b00, 1'b1, w4[j], 1'b0}, 10, "t4");
        chk("t4_busy_end", busy_n, 1'b0);
      end
    join

    // Reset mid DATA of the second frame
    if_n.tx_data = 8'hFF; if_n.tx_valid = 1'b1;
    tick();
    if_n.tx_data = 8'h00;
    tick();
    if_n.tx_data = 8'h33;
    tick();
    if_n.tx_valid = 1'b0;
    repeat (127) tick();
    chk("t5_pre_line", tx_n, 1'b0);
    chk("t5_pre_level", lvl_n, 3'd1);
    chk("t5_pre_busy", busy_n, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_line", tx_n, 1'b1);
    chk("t5_rst_level", lvl_n, 3'd0);
    chk("t5_rst_busy", busy_n, 1'b0);
    chk("t5_rst_ready", if_n.tx_ready, 1'b1);
    #3;
    reset_n = 1'b1;
    lows = 0;
    repeat (150) begin
      tick();
      if (tx_n !== 1'b1) lows++;
    end
    chk("t5_quiet_line", lows, 0);
    chk("t5_quiet_busy", busy_n, 1'b0);

`ifdef UART_TX_CTS_EN
    cts_n = 1'b1;
    repeat (3) tick();
    if_n.tx_valid = 1'b1;
    if_n.tx_data = 8'h11; tick();
    if_n.tx_data = 8'h22; tick();
    if_n.tx_data = 8'h33; tick();
    if_n.tx_valid = 1'b0;
    repeat (20) tick();
    chk("t6_held_line", tx_n, 1'b1);
    chk("t6_held_level", lvl_n, 3'd3);
    cts_n = 1'b0;
    cnt = 0;
    while (tx_n === 1'b1 && cnt < 10) begin tick(); cnt++; end
    chk("t6_start_latency", (cnt >= 1 && cnt <= 4), 1'b1);
    repeat (150) tick();
    cts_n = 1'b1;
    repeat (49) tick();
    chk("t6_f2_stop", tx_n, 1'b1);
    chk("t6_f2_busy", busy_n, 1'b1);
    tick();
    chk("t6_f3_held_level", lvl_n, 3'd1);
    repeat (30) tick();
    chk("t6_f3_held_line", tx_n, 1'b1);
    cts_n = 1'b0;
    cnt = 0;
    while (tx_n === 1'b1 && cnt < 10) begin tick(); cnt++; end
    chk("t6_f3_latency", (cnt >= 1 && cnt <= 4), 1'b1);
    repeat (110) tick();
    chk("t6_drained_level", lvl_n, 3'd0);
    chk("t6_drained_busy", busy_n, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
